// File: rtl/codec_ctrl_responder.sv
`default_nettype none
// ============================================================================
// Module      : codec_ctrl_responder
// Description : Slave end of a 3-wire codec control port. The module
//               synchronizes SCK/MOSI/CS into clk, shifts in 16-bit
//               {addr[6:0], data[8:0]} words and commits each one on the
//               rising edge of CS. Committed words update a 10 x 9-bit codec
//               register bank that has power-on defaults.
// Ports       : clk, reset        - system clock, synchronous active-high reset
//               spi_sck/mosi/cs   - asynchronous serial control inputs
//               wr_valid/addr/data- commit strobe and last committed word
//               frame_err         - CS rose with a bit count other than 16
//               addr_err          - committed address is not in the bank
//               soft_rst          - committed write to 0x0F (bank to defaults)
//               rd_addr/rd_data   - registered readback, 0 beyond index 9
//               active, out_pd    - decoded control bits R9[0], R6[4]
//               word_count        - wrapping count of well-formed commits
// Revision    : 1.0 - initial release
// ============================================================================
module codec_ctrl_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_BITS   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       frame_err,
    output logic       addr_err,
    output logic       soft_rst,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       active,
    output logic       out_pd,
    output logic [7:0] word_count
);

    localparam logic [4:0] c_full_cnt = 5'(WORD_BITS);
    localparam logic [4:0] c_sat_cnt  = 5'(WORD_BITS + 1);
    localparam int         c_regs     = 10;

    // Power-on register defaults; also restored by a write to 0x0F.
    function automatic logic [8:0] f_default(input int idx);
        logic [8:0] v;
        case (idx)
            0, 1:    v = 9'h097;
            2, 3:    v = 9'h079;
            4:       v = 9'h00A;
            5:       v = 9'h008;
            6:       v = 9'h09F;
            7:       v = 9'h00A;
            default: v = 9'h000;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Input synchronizers plus one history flop per edge-detected input
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sck_pipe;
    logic [SYNC_STAGES-1:0] r_mosi_pipe;
    logic [SYNC_STAGES-1:0] r_cs_pipe;
    logic                   r_sck_hist;
    logic                   r_cs_hist;

    logic w_sck;
    logic w_mosi;
    logic w_cs;
    logic w_sck_rise;
    logic w_cs_rise;

    assign w_sck  = r_sck_pipe[SYNC_STAGES-1];
    assign w_mosi = r_mosi_pipe[SYNC_STAGES-1];
    assign w_cs   = r_cs_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            // CS idles high, so loading ones avoids a false edge out of reset.
            r_sck_pipe  <= '0;
            r_mosi_pipe <= '0;
            r_cs_pipe   <= '1;
            r_sck_hist  <= 1'b0;
            r_cs_hist   <= 1'b1;
        end else begin
            r_sck_pipe  <= {r_sck_pipe[SYNC_STAGES-2:0], spi_sck};
            r_mosi_pipe <= {r_mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
            r_cs_pipe   <= {r_cs_pipe[SYNC_STAGES-2:0], spi_cs};
            r_sck_hist  <= w_sck;
            r_cs_hist   <= w_cs;
        end
    end

    assign w_sck_rise = w_sck & ~r_sck_hist;
    assign w_cs_rise  = w_cs & ~r_cs_hist;

    // ------------------------------------------------------------------------
    // Shift register, bit counter and commit decode
    // ------------------------------------------------------------------------
    logic [WORD_BITS-1:0] r_shift;
    logic [4:0]           r_bitcnt;
    logic                 r_wr_valid;
    logic                 r_frame_err;
    logic                 r_addr_err;
    logic                 r_soft_rst;
    logic [6:0]           r_wr_addr;
    logic [8:0]           r_wr_data;
    logic [7:0]           r_word_count;

    logic       w_commit;
    logic [6:0] w_addr;
    logic [8:0] w_data;
    logic       w_addr_known;

    // The commit uses the shift contents from before this cycle's SCK edge,
    // so a coincident SCK edge never leaks into the committed word.
    assign w_commit     = w_cs_rise && (r_bitcnt == c_full_cnt);
    assign w_addr       = r_shift[15:9];
    assign w_data       = r_shift[8:0];
    assign w_addr_known = (w_addr <= 7'h09) || (w_addr == 7'h0F);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_wr_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_addr_err   <= 1'b0;
            r_soft_rst   <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_word_count <= '0;
        end else begin
            r_wr_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_addr_err  <= 1'b0;
            r_soft_rst  <= 1'b0;

            // Shifting is independent of the CS level.
            if (w_sck_rise) begin
                r_shift <= {r_shift[WORD_BITS-2:0], w_mosi};
            end

            if (w_cs_rise) begin
                // A coincident SCK edge is the first bit of the next word.
                r_bitcnt <= w_sck_rise ? 5'd1 : 5'd0;
                if (w_commit) begin
                    r_wr_valid   <= 1'b1;
                    r_wr_addr    <= w_addr;
                    r_wr_data    <= w_data;
                    r_word_count <= r_word_count + 8'd1;
                    r_addr_err   <= ~w_addr_known;
                    r_soft_rst   <= (w_addr == 7'h0F);
                end else begin
                    r_frame_err  <= 1'b1;
                end
            end else if (w_sck_rise && (r_bitcnt != c_sat_cnt)) begin
                r_bitcnt <= r_bitcnt + 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register bank; written in the detect cycle so it is already updated
    // while wr_valid is high.
    // ------------------------------------------------------------------------
    logic [8:0] r_bank [0:c_regs-1];
    logic [8:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_regs; i++) begin
                r_bank[i] <= f_default(i);
            end
        end else if (w_commit) begin
            // R0/R1 and R2/R3 are channel pairs; data[8] updates both halves.
            case (w_addr)
                7'h00: begin
                    r_bank[0] <= w_data;
                    if (w_data[8]) r_bank[1] <= w_data;
                end
                7'h01: begin
                    r_bank[1] <= w_data;
                    if (w_data[8]) r_bank[0] <= w_data;
                end
                7'h02: begin
                    r_bank[2] <= w_data;
                    if (w_data[8]) r_bank[3] <= w_data;
                end
                7'h03: begin
                    r_bank[3] <= w_data;
                    if (w_data[8]) r_bank[2] <= w_data;
                end
                7'h04, 7'h05, 7'h06, 7'h07, 7'h08, 7'h09: begin
                    r_bank[w_addr[3:0]] <= w_data;
                end
                7'h0F: begin
                    for (int i = 0; i < c_regs; i++) begin
                        r_bank[i] <= f_default(i);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (rd_addr <= 4'd9) begin
            r_rd_data <= r_bank[rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign wr_valid   = r_wr_valid;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_err  = r_frame_err;
    assign addr_err   = r_addr_err;
    assign soft_rst   = r_soft_rst;
    assign rd_data    = r_rd_data;
    assign active     = r_bank[9][0];
    assign out_pd     = r_bank[6][4];
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_codec_ctrl_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_codec_ctrl_responder
// Description : Self-checking bench for codec_ctrl_responder. Drives SPI
//               frames (directed and random) and compares pulses, captured
//               words, word count and the full register bank against a
//               behavioural model of the codec register map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_codec_ctrl_responder;

    logic       clk;
    logic       reset;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_cs;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       frame_err;
    logic       addr_err;
    logic       soft_rst;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       active;
    logic       out_pd;
    logic [7:0] word_count;

    codec_ctrl_responder #(
        .SYNC_STAGES (2),
        .WORD_BITS   (16)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_cs     (spi_cs),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_err  (frame_err),
        .addr_err   (addr_err),
        .soft_rst   (soft_rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .active     (active),
        .out_pd     (out_pd),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitors: count high cycles, so a stretched pulse shows as >1.
    int         cnt_wv = 0;
    int         cnt_fe = 0;
    int         cnt_ae = 0;
    int         cnt_sr = 0;
    logic [6:0] cap_addr = '0;
    logic [8:0] cap_data = '0;

    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            cnt_wv   <= cnt_wv + 1;
            cap_addr <= wr_addr;
            cap_data <= wr_data;
        end
        if (frame_err === 1'b1) cnt_fe <= cnt_fe + 1;
        if (addr_err === 1'b1)  cnt_ae <= cnt_ae + 1;
        if (soft_rst === 1'b1)  cnt_sr <= cnt_sr + 1;
    end

    // ------------------------------------------------------------------------
    // Reference model of the codec register map
    // ------------------------------------------------------------------------
    int m_bank [10];
    int m_wc;
    int m_defaults [10] = '{'h097, 'h097, 'h079, 'h079, 'h00A, 'h008, 'h09F, 'h00A, 'h000, 'h000};

    function automatic void model_reset();
        for (int i = 0; i < 10; i++) m_bank[i] = m_defaults[i];
        m_wc = 0;
    endfunction

    // Applies one well-formed word; returns {soft_rst, addr_err}.
    function automatic logic [1:0] model_word(input int addr, input int data);
        logic [1:0] r;
        r = 2'b00;
        m_wc = (m_wc + 1) % 256;
        if (addr < 4) begin
            m_bank[addr] = data;
            if (data >= 256) m_bank[addr ^ 1] = data;  // data[8] links the pair
        end else if (addr < 10) begin
            m_bank[addr] = data;
        end else if (addr == 15) begin
            for (int i = 0; i < 10; i++) m_bank[i] = m_defaults[i];
            r[1] = 1'b1;
        end else begin
            r[0] = 1'b1;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = val[i];
            spi_sck  = 1'b0;
            hold(3);
            spi_sck  = 1'b1;
            hold(3);
        end
        spi_sck = 1'b0;
        hold(3);
    endtask

    task automatic check_state(input string tag);
        check_val({tag, " word_count"}, 32'(word_count), 32'(m_wc));
        check_val({tag, " active"}, 32'(active), 32'(m_bank[9] & 1));
        check_val({tag, " out_pd"}, 32'(out_pd), 32'((m_bank[6] >> 4) & 1));
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            hold(1);
            check_val($sformatf("%s rd[%0d]", tag, i), 32'(rd_data),
                      (i < 10) ? 32'(m_bank[i]) : 32'd0);
        end
    endtask

    // Sends one frame and checks every observable effect against the model.
    task automatic run_frame(input string tag, input logic [31:0] val, input int nbits);
        int b_wv, b_fe, b_ae, b_sr;
        int e_wv, e_fe, e_ae, e_sr;
        logic [1:0] fl;
        b_wv = cnt_wv; b_fe = cnt_fe; b_ae = cnt_ae; b_sr = cnt_sr;
        e_wv = 0; e_fe = 0; e_ae = 0; e_sr = 0;
        spi_cs = 1'b0;
        hold(3);
        shift_bits(val, nbits);
        spi_cs = 1'b1;
        hold(12);
        if (nbits == 16) begin
            fl   = model_word(int'(val[15:9]), int'(val[8:0]));
            e_wv = 1;
            e_ae = int'(fl[0]);
            e_sr = int'(fl[1]);
        end else begin
            e_fe = 1;
        end
        check_val({tag, " wr_valid"}, cnt_wv - b_wv, e_wv);
        check_val({tag, " frame_err"}, cnt_fe - b_fe, e_fe);
        check_val({tag, " addr_err"}, cnt_ae - b_ae, e_ae);
        check_val({tag, " soft_rst"}, cnt_sr - b_sr, e_sr);
        if (nbits == 16) begin
            check_val({tag, " wr_addr"}, 32'(cap_addr), 32'(val[15:9]));
            check_val({tag, " wr_data"}, 32'(cap_data), 32'(val[8:0]));
        end
        check_state(tag);
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        spi_cs = 1'b1;
        spi_sck = 1'b0;
        hold(3);
        reset = 1'b0;
        model_reset();
        hold(2);
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        int b_wv, b_fe;
        logic [15:0] wa, wb;
        int k, r, nb, addr;
        logic [31:0] val;

        reset    = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        spi_cs   = 1'b1;
        rd_addr  = '0;
        hold(2);
        apply_reset();

        check_val("reset wr_addr", 32'(wr_addr), 32'd0);
        check_val("reset wr_data", 32'(wr_data), 32'd0);
        check_val("reset pulses", 32'({wr_valid, frame_err, addr_err, soft_rst}), 32'd0);
        check_state("reset");

        run_frame("w0117", 32'h0117, 16);
        run_frame("w056E", 32'h056E, 16);
        run_frame("w0C10", 32'h0C10, 16);
        run_frame("w1201", 32'h1201, 16);
        run_frame("w0C00", 32'h0C00, 16);
        run_frame("short15", 32'h1201 >> 1, 15);
        run_frame("after15", 32'h1201, 16);
        run_frame("long18", 32'h2_0C10, 18);
        run_frame("empty", 32'h0, 0);
        run_frame("badaddr", 32'h1400, 16);
        run_frame("softrst", 32'h1E00, 16);

        // Reset in the middle of a frame discards the partial word.
        spi_cs = 1'b0;
        hold(3);
        shift_bits(32'h01, 8);
        apply_reset();
        check_state("midreset");
        run_frame("postrst", 32'h0117, 16);

        // SCK edge coincident with the CS edge starts the next word.
        wa = 16'h0B55;
        wb = 16'h0E93;
        b_wv = cnt_wv;
        b_fe = cnt_fe;
        spi_cs = 1'b0;
        hold(3);
        shift_bits({16'h0, wa}, 16);
        spi_mosi = wb[15];
        spi_sck  = 1'b1;
        spi_cs   = 1'b1;
        hold(3);
        spi_sck = 1'b0;
        hold(3);
        spi_cs = 1'b0;
        hold(3);
        shift_bits({17'h0, wb[14:0]}, 15);
        spi_cs = 1'b1;
        hold(12);
        void'(model_word(int'(wa[15:9]), int'(wa[8:0])));
        void'(model_word(int'(wb[15:9]), int'(wb[8:0])));
        check_val("coinc wr_valid", cnt_wv - b_wv, 2);
        check_val("coinc frame_err", cnt_fe - b_fe, 0);
        check_val("coinc wr_data", 32'(cap_data), 32'(wb[8:0]));
        check_state("coinc");

        // Randomized frames.
        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 11));
            nb = (r == 0) ? 15 : (r == 1) ? 17 : (r == 2) ? 18 : (r == 3) ? 0 : 16;
            k = int'($urandom_range(0, 12));
            addr = (k < 10) ? k : (k == 10) ? 15 : int'($urandom_range(16, 127));
            val = {$urandom_range(0, 3), 7'(addr), 9'($urandom_range(0, 511))};
            val[31:18] = '0;
            run_frame($sformatf("rnd%0d", t), val, nb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
